xgmii_scrambler: RTL
====================

Name: xgmii_scrambler

Overview:
- Self-synchronising 64b/66b scrambler, polynomial G(x) = 1 + x^39 + x^58, on a 32-bit datapath.
- Sits directly downstream of the 64b/66b encoder and upstream of the TX gearbox.
- Scrambles the 64-bit block payload as two 32-bit words. The 2-bit sync header passes through unscrambled, tagged on the first word of each block.
- Full-throughput valid/ready on both sides, with a registered upstream ready (skid buffer).

Parameters:
- DATA_WIDTH, 32, payload word width; only 32 supported.
- HDR_WIDTH, 2, sync header width.
- SCRAMBLER_SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state loaded at reset.

Ports:
- i_clk  in  1  single clock (XGMII/PCS domain).
- i_reset  in  1  synchronous active-high reset.
- i_encoded_data  in  32  encoder payload word; bit 0 is first transmitted.
- i_encoded_data_valid  in  1  payload word valid.
- i_sync_hdr  in  2  block sync header; sampled only on the first word of a block.
- o_scrambler_trdy  out  1  ready to encoder; registered.
- i_scrambler_bypass  in  1  1 = data passes unscrambled but state still advances (test only).
- o_scrambled_data  out  32  scrambled payload word.
- o_scrambled_valid  out  1  output word valid.
- o_sync_hdr  out  2  header of the current block.
- o_hdr_valid  out  1  1 on the first (even) word of each block.
- i_gearbox_trdy  in  1  downstream ready.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset. All state clears at the i_clk edge where i_reset=1.
- Reset values:
  - scrambler state = SCRAMBLER_SEED
  - word phase = 0
  - o_scrambled_valid = 0
  - o_hdr_valid = 0
  - o_scrambled_data = 0
  - o_sync_hdr = 2'b00
  - skid buffer empty
  - o_scrambler_trdy = 0 during reset, 1 on the first cycle after reset.
- Input transfer: occurs when i_encoded_data_valid & o_scrambler_trdy.
- Output transfer: occurs when o_scrambled_valid & i_gearbox_trdy. Output signals hold stable while o_scrambled_valid=1 and i_gearbox_trdy=0.
- Scrambling:
  - Bits are processed serially, LSB first, within one cycle: out[i] = in[i] ^ S[38] ^ S[57], then S = {S[56:0], out[i]}.
  - After 32 bits the updated 58-bit state is registered.
  - The state advances only on an input transfer, never on stalls.
  - Equivalent closed form: out_n = in_n ^ out_(n-39) ^ out_(n-58) across the continuous bit stream.
- Bypass: when i_scrambler_bypass=1, the output equals the input. The state still updates with the would-be scrambled bits, so deasserting bypass mid-stream does not desynchronise.
- Word phase:
  - A 1-bit counter toggles on each input transfer.
  - On phase 0: i_sync_hdr is captured and o_hdr_valid=1 for that word.
  - On phase 1: o_sync_hdr repeats the captured header and o_hdr_valid=0.
  - A header of 2'b00 or 2'b11 is forwarded unchanged; the gearbox owns error handling.
- Latency: 1 cycle from input transfer to o_scrambled_valid when the output register is free.
- Skid buffer:
  - One output register plus one skid entry.
  - o_scrambler_trdy = skid entry empty, registered.
  - If the output is stalled and an input transfer occurs, the word goes to the skid entry and trdy drops on the next cycle.
  - When the output drains, the skid entry moves to the output register and trdy reasserts.
  - No word is lost or duplicated. Simultaneous drain and fill keeps full throughput.
- Reset mid-block: the phase returns to 0 and the state to the seed; a partially transferred block is discarded.
- Idle gaps (valid=0) do not change the phase or the state.

Test Plan:
- SCRAMBLER_SEED=0, gearbox ready, input words 32'h0000_0001 then 32'h0000_0000 with hdr 2'b10 -> outputs 32'h0000_0001 then 32'h0400_0080; o_hdr_valid = 1 then 0; o_sync_hdr = 2'b10 on both.
- Random 1000-word stream with random valid gaps -> output equals a bit-serial reference model; output passed through a reference descrambler equals the input.
- Hold i_gearbox_trdy=0 for 5 cycles during a continuous stream -> trdy deasserts after the skid entry fills; output stays stable; all words delivered in order with none dropped.
- Assert i_scrambler_bypass for 4 words, then deassert -> bypass words appear unchanged; subsequent words match the reference model run with continuous state.
- Assert i_reset after a phase-0 word only -> next input word is treated as phase 0 (o_hdr_valid=1); state restarts from SCRAMBLER_SEED.
- Back-to-back transfers with i_gearbox_trdy toggling every cycle -> no loss or duplication; headers stay aligned to even words.

Source files
------------

// File: rtl/xgmii_scrambler.sv
// Self-synchronising 64b/66b scrambler (G(x) = 1 + x^39 + x^58) on a 32-bit datapath.
// Tags the sync header on the even word of each block and buffers output with one skid entry.
module xgmii_scrambler #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          HDR_WIDTH      = 2,
  parameter logic [57:0] SCRAMBLER_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_encoded_data,
  input  logic                  i_encoded_data_valid,
  input  logic [HDR_WIDTH-1:0]  i_sync_hdr,
  output logic                  o_scrambler_trdy,
  input  logic                  i_scrambler_bypass,
  output logic [DATA_WIDTH-1:0] o_scrambled_data,
  output logic                  o_scrambled_valid,
  output logic [HDR_WIDTH-1:0]  o_sync_hdr,
  output logic                  o_hdr_valid,
  input  logic                  i_gearbox_trdy
);

  // Bit-serial LFSR walk over one word, LSB first; returns {next_state, scrambled_word}.
  function automatic logic [DATA_WIDTH+57:0] scramble_word(
    input logic [57:0]           state,
    input logic [DATA_WIDTH-1:0] din
  );
    logic [57:0]           s;
    logic [DATA_WIDTH-1:0] dout;
    logic                  b;
    s    = state;
    dout = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      b       = din[i] ^ s[38] ^ s[57];
      dout[i] = b;
      s       = {s[56:0], b};
    end
    return {s, dout};
  endfunction

  logic [57:0]           state_q, state_d;
  logic                  phase_q, phase_d;
  logic [HDR_WIDTH-1:0]  hdr_cap_q, hdr_cap_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [HDR_WIDTH-1:0]  out_hdr_q, out_hdr_d;
  logic                  out_hdr_valid_q, out_hdr_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [HDR_WIDTH-1:0]  skid_hdr_q, skid_hdr_d;
  logic                  skid_hdr_valid_q, skid_hdr_valid_d;
  logic                  trdy_q, trdy_d;

  logic [DATA_WIDTH+57:0] scr_result;
  logic                   in_xfer;
  logic                   out_free;
  logic [DATA_WIDTH-1:0]  new_data;
  logic [HDR_WIDTH-1:0]   new_hdr;
  logic                   new_hdr_valid;

  // Next-state: scrambler state, word phase, output register and skid entry.
  always_comb begin
    scr_result       = scramble_word(state_q, i_encoded_data);
    in_xfer          = i_encoded_data_valid & trdy_q;
    out_free         = ~out_valid_q | i_gearbox_trdy;
    new_hdr_valid    = ~phase_q;
    state_d          = state_q;
    phase_d          = phase_q;
    hdr_cap_d        = hdr_cap_q;
    out_data_d       = out_data_q;
    out_valid_d      = out_valid_q;
    out_hdr_d        = out_hdr_q;
    out_hdr_valid_d  = out_hdr_valid_q;
    skid_data_d      = skid_data_q;
    skid_valid_d     = skid_valid_q;
    skid_hdr_d       = skid_hdr_q;
    skid_hdr_valid_d = skid_hdr_valid_q;

    if (i_scrambler_bypass) begin
      new_data = i_encoded_data;
    end else begin
      new_data = scr_result[DATA_WIDTH-1:0];
    end

    if (phase_q) begin
      new_hdr = hdr_cap_q;
    end else begin
      new_hdr = i_sync_hdr;
    end

    // State advances with the would-be scrambled bits even in bypass.
    if (in_xfer) begin
      state_d   = scr_result[DATA_WIDTH+57:DATA_WIDTH];
      phase_d   = ~phase_q;
      hdr_cap_d = new_hdr;
    end else begin
      state_d   = state_q;
      phase_d   = phase_q;
      hdr_cap_d = hdr_cap_q;
    end

    if (skid_valid_q) begin
      if (out_free) begin
        out_data_d      = skid_data_q;
        out_hdr_d       = skid_hdr_q;
        out_hdr_valid_d = skid_hdr_valid_q;
        out_valid_d     = 1'b1;
        skid_valid_d    = 1'b0;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else if (in_xfer) begin
      if (out_free) begin
        out_data_d      = new_data;
        out_hdr_d       = new_hdr;
        out_hdr_valid_d = new_hdr_valid;
        out_valid_d     = 1'b1;
      end else begin
        skid_data_d      = new_data;
        skid_hdr_d       = new_hdr;
        skid_hdr_valid_d = new_hdr_valid;
        skid_valid_d     = 1'b1;
      end
    end else begin
      if (out_free) begin
        out_valid_d     = 1'b0;
        out_hdr_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end

    trdy_d = ~skid_valid_d;
  end

  // State registers with synchronous reset; ready is held low throughout reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q          <= SCRAMBLER_SEED;
      phase_q          <= 1'b0;
      hdr_cap_q        <= '0;
      out_data_q       <= '0;
      out_valid_q      <= 1'b0;
      out_hdr_q        <= '0;
      out_hdr_valid_q  <= 1'b0;
      skid_data_q      <= '0;
      skid_valid_q     <= 1'b0;
      skid_hdr_q       <= '0;
      skid_hdr_valid_q <= 1'b0;
      trdy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      hdr_cap_q        <= hdr_cap_d;
      out_data_q       <= out_data_d;
      out_valid_q      <= out_valid_d;
      out_hdr_q        <= out_hdr_d;
      out_hdr_valid_q  <= out_hdr_valid_d;
      skid_data_q      <= skid_data_d;
      skid_valid_q     <= skid_valid_d;
      skid_hdr_q       <= skid_hdr_d;
      skid_hdr_valid_q <= skid_hdr_valid_d;
      trdy_q           <= trdy_d;
    end
  end

  assign o_scrambler_trdy  = trdy_q;
  assign o_scrambled_data  = out_data_q;
  assign o_scrambled_valid = out_valid_q;
  assign o_sync_hdr        = out_hdr_q;
  assign o_hdr_valid       = out_hdr_valid_q;

endmodule
